trigger_conditioner: RTL and testbench



---
 rtl/trigger_conditioner.sv | 169 ++++++++++++++++
 tb/tb_trigger_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_conditioner.sv
// Conditions the raw 100 Hz machine trigger: synchronises it, rejects glitches, locks onto
// the nominal period and flywheels over missing triggers before handing off to pulse_id_gen.
module trigger_conditioner #(
  parameter int NOMINAL_PERIOD = 800000,
  parameter int TOLERANCE      = 800,
  parameter int HOLDOFF        = 8000,
  parameter int LOCK_COUNT     = 4,
  parameter int MAX_MISS       = 3
) (
  input  logic        clk_80_Mhz,
  input  logic        reset,
  input  logic        trigger_i,
  input  logic        inhibit_i,
  output logic        trigger_o,
  output logic        locked_o,
  output logic        missing_o,
  output logic [23:0] period_o,
  output logic [15:0] error_count_o
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED, FLYWHEEL} state_t;

  localparam logic [24:0] WIN_LO   = 25'(NOMINAL_PERIOD - TOLERANCE);
  localparam logic [24:0] WIN_HI   = 25'(NOMINAL_PERIOD + TOLERANCE);
  localparam logic [24:0] HOLD     = 25'(HOLDOFF);
  localparam logic [23:0] CNT_TOL  = 24'(TOLERANCE);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0]  MISS_MAX = 8'(MAX_MISS);

  state_t      state_q, state_d;
  logic        trigSync1_q, trigSync2_q, trigSync3_q;
  logic        inhSync1_q, inhSync2_q;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  miss_q, miss_d;
  logic [23:0] period_q, period_d;
  logic [15:0] errCount_q, errCount_d;
  logic        trigger_q, trigger_d;
  logic        missing_q, missing_d;

  logic        edgeDet, afterHold, inWin, winClose, fire, errInc;
  logic [24:0] p;
  logic [23:0] pSat;

  // p is kept one bit wider so a saturated counter never wraps into the holdoff range
  assign p         = {1'b0, cnt_q} + 25'd1;
  assign pSat      = p[24] ? '1 : p[23:0];
  assign edgeDet   = trigSync2_q & ~trigSync3_q;
  assign afterHold = p > HOLD;
  assign inWin     = (p >= WIN_LO) && (p <= WIN_HI);
  assign winClose  = (p == WIN_HI) && !edgeDet;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 24'd1;
    good_d    = good_q;
    miss_d    = miss_q;
    period_d  = period_q;
    missing_d = 1'b0;
    fire      = 1'b0;
    errInc    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (edgeDet) begin
          state_d = TRACK;
          good_d  = '0;
          miss_d  = '0;
          cnt_d   = '0;
        end
      end
      TRACK: begin
        if (edgeDet) begin
          if (!afterHold) begin
            errInc = 1'b1;
          end else begin
            cnt_d    = '0;
            period_d = pSat;
            if (inWin && (good_q + 8'd1 == LOCK_N)) begin
              state_d = LOCKED;
              good_d  = '0;
              fire    = 1'b1;
            end else if (inWin) begin
              good_d = good_q + 8'd1;
            end else begin
              good_d = '0;
            end
          end
        end else if (winClose) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      LOCKED, FLYWHEEL: begin
        if (edgeDet) begin
          if (!afterHold) begin
            errInc = 1'b1;
          end else begin
            cnt_d    = '0;
            period_d = pSat;
            miss_d   = '0;
            if (inWin) begin
              state_d = LOCKED;
              fire    = 1'b1;
            end else begin
              state_d = TRACK;
              good_d  = '0;
              errInc  = 1'b1;
            end
          end
        end else if (winClose) begin
          // Reloading with TOLERANCE keeps the synthetic schedule on the nominal grid
          if (state_q == LOCKED || miss_q < MISS_MAX) begin
            state_d   = FLYWHEEL;
            fire      = 1'b1;
            missing_d = 1'b1;
            errInc    = 1'b1;
            miss_d    = miss_q + 8'd1;
            cnt_d     = CNT_TOL;
          end else begin
            state_d = SEARCH;
            miss_d  = '0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
    trigger_d  = fire & ~inhSync2_q;
    errCount_d = (errInc && errCount_q != 16'hFFFF) ? errCount_q + 16'd1 : errCount_q;
  end

  always_ff @(posedge clk_80_Mhz) begin
    if (reset) begin
      state_q     <= SEARCH;
      trigSync1_q <= 1'b0;
      trigSync2_q <= 1'b0;
      trigSync3_q <= 1'b0;
      inhSync1_q  <= 1'b0;
      inhSync2_q  <= 1'b0;
      cnt_q       <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      period_q    <= '0;
      errCount_q  <= '0;
      trigger_q   <= 1'b0;
      missing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      trigSync1_q <= trigger_i;
      trigSync2_q <= trigSync1_q;
      trigSync3_q <= trigSync2_q;
      inhSync1_q  <= inhibit_i;
      inhSync2_q  <= inhSync1_q;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      period_q    <= period_d;
      errCount_q  <= errCount_d;
      trigger_q   <= trigger_d;
      missing_q   <= missing_d;
    end
  end

  assign trigger_o     = trigger_q;
  assign missing_o     = missing_q;
  assign locked_o      = (state_q == LOCKED) || (state_q == FLYWHEEL);
  assign period_o      = period_q;
  assign error_count_o = errCount_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Scoreboard bench for trigger_conditioner: expected triggers are queued with their cycle
// and status values when stimulus is driven, and matched whenever trigger_o/missing_o fire.
`timescale 1ns/1ps
module tb_trigger_conditioner;

  localparam int NOM  = 1000;
  localparam int TOL  = 10;
  localparam int HOLD = 100;

  logic        clk_80_Mhz = 1'b0;
  logic        reset      = 1'b1;
  logic        trigger_i  = 1'b0;
  logic        inhibit_i  = 1'b0;
  logic        trigger_o, locked_o, missing_o;
  logic [23:0] period_o;
  logic [15:0] error_count_o;

  typedef struct {
    int          cyc;
    logic        missing;
    logic [23:0] period;
    logic [15:0] errors;
  } expect_t;

  expect_t expQ[$];
  expect_t mon;
  int      cyc       = 0;
  int      lastDrive = 0;
  int      checks    = 0;
  int      errors    = 0;

  trigger_conditioner #(
    .NOMINAL_PERIOD(NOM),
    .TOLERANCE     (TOL),
    .HOLDOFF       (HOLD),
    .LOCK_COUNT    (4),
    .MAX_MISS      (3)
  ) dut (
    .clk_80_Mhz   (clk_80_Mhz),
    .reset        (reset),
    .trigger_i    (trigger_i),
    .inhibit_i    (inhibit_i),
    .trigger_o    (trigger_o),
    .locked_o     (locked_o),
    .missing_o    (missing_o),
    .period_o     (period_o),
    .error_count_o(error_count_o)
  );

  always #6.25 clk_80_Mhz = ~clk_80_Mhz;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Output monitor: any trigger pulse must match the oldest queued expectation
  always @(negedge clk_80_Mhz) begin
    cyc = cyc + 1;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      mon = expQ.pop_front();
      checkOutput("trig_timeout", cyc, mon.cyc);
    end
    if (trigger_o || missing_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_trigger", {30'd0, trigger_o, missing_o}, 32'd0);
      end else begin
        mon = expQ.pop_front();
        checkOutput("trig_cycle", cyc, mon.cyc);
        checkOutput("trigger_o", {31'd0, trigger_o}, 32'd1);
        checkOutput("missing_o", {31'd0, missing_o}, {31'd0, mon.missing});
        checkOutput("locked_o", {31'd0, locked_o}, 32'd1);
        checkOutput("period_o", {8'd0, period_o}, {8'd0, mon.period});
        checkOutput("error_count_o", {16'd0, error_count_o}, {16'd0, mon.errors});
      end
    end
  end

  task automatic waitCycle(input int target);
    while (cyc < target) begin
      @(negedge clk_80_Mhz);
      #1;
    end
  endtask

  task automatic pushExpect(input int c, input logic m, input logic [23:0] p, input logic [15:0] e);
    expect_t x;
    x.cyc     = c;
    x.missing = m;
    x.period  = p;
    x.errors  = e;
    expQ.push_back(x);
  endtask

  // Drives a 4-cycle trigger pulse gap cycles after the previous one; trigger_o lands 3 cycles later
  task automatic applyStimulus(input int gap, input bit expTrig, input logic [23:0] expPeriod,
                               input logic [15:0] expErr);
    waitCycle(lastDrive + gap);
    trigger_i = 1'b1;
    lastDrive = cyc;
    if (expTrig) pushExpect(cyc + 3, 1'b0, expPeriod, expErr);
    waitCycle(cyc + 4);
    trigger_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_trigger"}, {31'd0, trigger_o}, 32'd0);
    checkOutput({tag, "_locked"}, {31'd0, locked_o}, 32'd0);
    checkOutput({tag, "_missing"}, {31'd0, missing_o}, 32'd0);
    checkOutput({tag, "_period"}, {8'd0, period_o}, 32'd0);
    checkOutput({tag, "_errors"}, {16'd0, error_count_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int L;
    waitCycle(3);
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] lock acquisition");
    lastDrive = cyc;
    applyStimulus(20, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(NOM, 0, 0, 0);
    checkOutput("tracking_unlocked", {31'd0, locked_o}, 32'd0);
    applyStimulus(NOM, 1, 1000, 0);
    applyStimulus(NOM, 1, 1000, 0);

    $display("[TB] jitter and window boundaries");
    applyStimulus(990, 1, 990, 0);
    applyStimulus(1010, 1, 1010, 0);
    applyStimulus(989, 0, 0, 0);
    checkOutput("early_unlocked", {31'd0, locked_o}, 32'd0);
    checkOutput("early_errors", {16'd0, error_count_o}, 32'd1);
    checkOutput("early_period", {8'd0, period_o}, 32'd989);
    for (int i = 0; i < 3; i++) applyStimulus(NOM, 0, 0, 0);
    applyStimulus(NOM, 1, 1000, 1);

    $display("[TB] glitch rejection");
    applyStimulus(50, 0, 0, 0);
    checkOutput("glitch_errors", {16'd0, error_count_o}, 32'd2);
    checkOutput("glitch_period", {8'd0, period_o}, 32'd1000);
    checkOutput("glitch_locked", {31'd0, locked_o}, 32'd1);
    applyStimulus(950, 1, 1000, 2);

    $display("[TB] inhibit");
    inhibit_i = 1'b1;
    applyStimulus(NOM, 0, 0, 0);
    applyStimulus(997, 0, 0, 0);
    applyStimulus(1003, 0, 0, 0);
    checkOutput("inhibit_locked", {31'd0, locked_o}, 32'd1);
    checkOutput("inhibit_period", {8'd0, period_o}, 32'd1003);
    checkOutput("inhibit_errors", {16'd0, error_count_o}, 32'd2);
    inhibit_i = 1'b0;
    applyStimulus(NOM, 1, 1000, 2);

    $display("[TB] flywheel with resume");
    L = lastDrive;
    pushExpect(L + 3 + 1010, 1'b1, 1000, 3);
    pushExpect(L + 3 + 2010, 1'b1, 1000, 4);
    applyStimulus(3000, 1, 1000, 4);
    checkOutput("resume_locked", {31'd0, locked_o}, 32'd1);
    applyStimulus(NOM, 1, 1000, 4);

    $display("[TB] flywheel to loss of lock");
    L = lastDrive;
    pushExpect(L + 3 + 1010, 1'b1, 1000, 5);
    pushExpect(L + 3 + 2010, 1'b1, 1000, 6);
    pushExpect(L + 3 + 3010, 1'b1, 1000, 7);
    waitCycle(L + 3 + 4009);
    checkOutput("flywheel_still_locked", {31'd0, locked_o}, 32'd1);
    waitCycle(L + 3 + 4010);
    checkOutput("flywheel_lost_lock", {31'd0, locked_o}, 32'd0);
    checkOutput("flywheel_errors", {16'd0, error_count_o}, 32'd7);
    waitCycle(L + 4100);

    $display("[TB] relock from search");
    lastDrive = cyc;
    applyStimulus(500, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(NOM, 0, 0, 0);
    applyStimulus(NOM, 1, 1000, 7);

    $display("[TB] reset mid-period");
    waitCycle(lastDrive + 400);
    reset = 1'b1;
    waitCycle(cyc + 1);
    reset = 1'b0;
    checkAllZero("midreset");
    lastDrive = cyc;
    applyStimulus(600, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(NOM, 0, 0, 0);
    checkOutput("postreset_unlocked", {31'd0, locked_o}, 32'd0);
    applyStimulus(NOM, 1, 1000, 0);
    applyStimulus(NOM, 1, 1000, 0);

    waitCycle(cyc + 20);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
